// File: rtl/wb_stage_pkg.sv
// Shared widths, state encoding and timer sizing for the write-back stage.
// Width defaults alias the register-file length defines when present.
`ifndef REGISTER_FILE_LEN
`define REGISTER_FILE_LEN 32
`endif
`ifndef REGISTER_FILE_ADDRESS_LEN
`define REGISTER_FILE_ADDRESS_LEN 4
`endif

package wb_stage_pkg;

  localparam int WB_DATA_W      = `REGISTER_FILE_LEN;
  localparam int WB_ADDR_W      = `REGISTER_FILE_ADDRESS_LEN;
  localparam int WB_MEM_TIMEOUT = 16;

  typedef enum logic {
    WB_STATE_IDLE     = 1'b0,
    WB_STATE_WAIT_MEM = 1'b1
  } wb_state_e;

  // A one-cycle timeout still needs a 1-bit counter.
  function automatic int timer_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Retire, memory-response and register-file write signals of the write-back stage.
// WB_BYPASS_EN adds the combinational forwarding signals.
interface wb_stage_if #(
  parameter int DATA_W = wb_stage_pkg::WB_DATA_W,
  parameter int ADDR_W = wb_stage_pkg::WB_ADDR_W
);

  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic              in_mem_r_en;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              freeze;
  logic              timeout_err;
  logic [31:0]       retire_count;
`ifdef WB_BYPASS_EN
  logic              byp_valid;
  logic [ADDR_W-1:0] byp_dest;
  logic [DATA_W-1:0] byp_value;
`endif

  modport slave (
    input  in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result,
    input  mem_rdata, mem_rvalid,
`ifdef WB_BYPASS_EN
    output byp_valid, byp_dest, byp_value,
`endif
    output in_ready, wb_en, wb_dest, wb_value, freeze, timeout_err, retire_count
  );

  modport master (
    output in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result,
    output mem_rdata, mem_rvalid,
`ifdef WB_BYPASS_EN
    input  byp_valid, byp_dest, byp_value,
`endif
    input  in_ready, wb_en, wb_dest, wb_value, freeze, timeout_err, retire_count
  );

endinterface

// File: rtl/wb_stage_mem_wait_timer.sv
// Clear/enable counter flagging terminal count at MEM_TIMEOUT-1; clear wins over enable.
module mem_wait_timer
  import wb_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = WB_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = timer_width(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TERM);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly and parks loads in WAIT_MEM until
// data or watchdog expiry. Optional WB_BYPASS_EN exposes next-cycle write values.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int MEM_TIMEOUT = WB_MEM_TIMEOUT
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ld_dest_q, ld_dest_d;
  logic              ld_wb_en_q, ld_wb_en_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_value_q, wb_value_d;
  logic              timeout_err_q, timeout_err_d;
  logic [31:0]       retire_count_q, retire_count_d;
  logic              in_ready;
  logic              freeze;
  logic              xfer;
  logic              load_xfer;
  logic              tc;

  assign xfer      = bus.in_valid && in_ready;
  assign load_xfer = xfer && bus.in_mem_r_en;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (load_xfer),
    .en  (state_q == WB_STATE_WAIT_MEM),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_STATE_IDLE:     if (load_xfer) state_d = WB_STATE_WAIT_MEM;
      WB_STATE_WAIT_MEM: if (bus.mem_rvalid || tc) state_d = WB_STATE_IDLE;
      default:           state_d = WB_STATE_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == WB_STATE_IDLE);
    freeze   = (state_q == WB_STATE_WAIT_MEM);
  end

  // Data arriving in the terminal-count cycle retires normally and suppresses the error.
  always_comb begin
    ld_dest_d      = ld_dest_q;
    ld_wb_en_d     = ld_wb_en_q;
    wb_en_d        = 1'b0;
    wb_dest_d      = wb_dest_q;
    wb_value_d     = wb_value_q;
    timeout_err_d  = timeout_err_q;
    retire_count_d = retire_count_q;
    if (state_q == WB_STATE_IDLE) begin
      if (load_xfer) begin
        ld_dest_d  = bus.in_dest;
        ld_wb_en_d = bus.in_wb_en;
      end else if (xfer) begin
        wb_en_d        = bus.in_wb_en;
        wb_dest_d      = bus.in_dest;
        wb_value_d     = bus.in_alu_result;
        retire_count_d = retire_count_q + 32'd1;
      end
    end else if (bus.mem_rvalid) begin
      wb_en_d        = ld_wb_en_q;
      wb_dest_d      = ld_dest_q;
      wb_value_d     = bus.mem_rdata;
      retire_count_d = retire_count_q + 32'd1;
    end else if (tc) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_dest_q      <= '0;
      ld_wb_en_q     <= 1'b0;
      wb_en_q        <= 1'b0;
      wb_dest_q      <= '0;
      wb_value_q     <= '0;
      timeout_err_q  <= 1'b0;
      retire_count_q <= '0;
    end else begin
      ld_dest_q      <= ld_dest_d;
      ld_wb_en_q     <= ld_wb_en_d;
      wb_en_q        <= wb_en_d;
      wb_dest_q      <= wb_dest_d;
      wb_value_q     <= wb_value_d;
      timeout_err_q  <= timeout_err_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.freeze       = freeze;
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.wb_value     = wb_value_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.retire_count = retire_count_q;

`ifdef WB_BYPASS_EN
  assign bus.byp_valid = wb_en_d;
  assign bus.byp_dest  = wb_dest_d;
  assign bus.byp_value = wb_value_d;
`endif

endmodule
